alu_share_arb: RTL

- Shares one combinational ALU between two requesters, e.g. the main execute path (port 0) and a multi-cycle helper such as an address or branch unit (port 1).
- Each port has a valid/ready request channel and a valid/ready response channel.
- The block arbitrates between ports (round-robin), registers the operands into the ALU, and captures alu_c/alu_f.
- It returns the result only to the owning requester.

---
 rtl/alu_share_arb_if.sv | 39 +++
 rtl/alu_share_arb.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alu_share_arb_if.sv
// Request/response and ALU-side bus of alu_share_arb.
// slave = the arbiter; master = the two requesters plus the shared ALU.
interface alu_share_arb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*DATA_W-1:0] req_data_1;
  logic [2*DATA_W-1:0] req_data_2;
  logic [2*DATA_W-1:0] req_imm;
  logic [2*OP_W-1:0]   req_alu_op;
  logic [1:0]          req_alu_b_sel;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_c;
  logic                rsp_f;
  logic [DATA_W-1:0]   alu_data_1;
  logic [DATA_W-1:0]   alu_data_2;
  logic [DATA_W-1:0]   alu_imm;
  logic [OP_W-1:0]     alu_op;
  logic                alu_b_sel;
  logic [DATA_W-1:0]   alu_c;
  logic                alu_f;

  modport slave (
    input  req_valid, req_data_1, req_data_2, req_imm, req_alu_op, req_alu_b_sel,
    input  rsp_ready, alu_c, alu_f,
    output req_ready, rsp_valid, rsp_c, rsp_f,
    output alu_data_1, alu_data_2, alu_imm, alu_op, alu_b_sel
  );

  modport master (
    output req_valid, req_data_1, req_data_2, req_imm, req_alu_op, req_alu_b_sel,
    output rsp_ready, alu_c, alu_f,
    input  req_ready, rsp_valid, rsp_c, rsp_f,
    input  alu_data_1, alu_data_2, alu_imm, alu_op, alu_b_sel
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin share of one combinational ALU between two requesters.
// Optional statistics counters are compiled in with ALU_ARB_STAT_EN.
module alu_share_arb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_share_arb_if.slave   bus
`ifdef ALU_ARB_STAT_EN
  ,
  output logic [15:0]      gnt_cnt0,
  output logic [15:0]      gnt_cnt1,
  output logic [15:0]      busy_cnt
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

  state_e              state_q;
  logic                owner_q;
  logic                last_gnt_q;
  logic [1:0]          rsp_valid_q;
  logic [DATA_W-1:0]   rsp_c_q;
  logic                rsp_f_q;
  logic [DATA_W-1:0]   alu_data_1_q;
  logic [DATA_W-1:0]   alu_data_2_q;
  logic [DATA_W-1:0]   alu_imm_q;
  logic [OP_W-1:0]     alu_op_q;
  logic                alu_b_sel_q;

  logic                gnt_c;
  logic                accept_c;
  logic                rsp_hs_c;
  logic [1:0]          req_ready_c;

  // Grant selection: lone requester wins, contention goes to the port not served last.
  always_comb begin
    gnt_c = 1'b0;
    case (bus.req_valid)
      2'b10:   gnt_c = 1'b1;
      2'b11:   gnt_c = ~last_gnt_q;
      default: gnt_c = 1'b0;
    endcase
  end

  // Handshake decode; ready is only offered in IDLE and never while reset is held.
  always_comb begin
    req_ready_c = 2'b00;
    if (state_q == ST_IDLE && rst_n) begin
      req_ready_c = {bus.req_valid[1] & gnt_c, bus.req_valid[0] & ~gnt_c};
    end
    accept_c = (state_q == ST_IDLE) && (|bus.req_valid);
    rsp_hs_c = (state_q == ST_RESP) && (owner_q ? bus.rsp_ready[1] : bus.rsp_ready[0]);
  end

  // Arbitration FSM with registered ALU operands and captured result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_gnt_q   <= 1'b1;
      rsp_valid_q  <= 2'b00;
      rsp_c_q      <= '0;
      rsp_f_q      <= 1'b0;
      alu_data_1_q <= '0;
      alu_data_2_q <= '0;
      alu_imm_q    <= '0;
      alu_op_q     <= '0;
      alu_b_sel_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            if (gnt_c) begin
              alu_data_1_q <= bus.req_data_1[2*DATA_W-1:DATA_W];
              alu_data_2_q <= bus.req_data_2[2*DATA_W-1:DATA_W];
              alu_imm_q    <= bus.req_imm[2*DATA_W-1:DATA_W];
              alu_op_q     <= bus.req_alu_op[2*OP_W-1:OP_W];
              alu_b_sel_q  <= bus.req_alu_b_sel[1];
            end else begin
              alu_data_1_q <= bus.req_data_1[DATA_W-1:0];
              alu_data_2_q <= bus.req_data_2[DATA_W-1:0];
              alu_imm_q    <= bus.req_imm[DATA_W-1:0];
              alu_op_q     <= bus.req_alu_op[OP_W-1:0];
              alu_b_sel_q  <= bus.req_alu_b_sel[0];
            end
            owner_q <= gnt_c;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_c_q     <= bus.alu_c;
          rsp_f_q     <= bus.alu_f;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_hs_c) begin
            rsp_valid_q <= 2'b00;
            last_gnt_q  <= owner_q;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_c      = rsp_c_q;
  assign bus.rsp_f      = rsp_f_q;
  assign bus.alu_data_1 = alu_data_1_q;
  assign bus.alu_data_2 = alu_data_2_q;
  assign bus.alu_imm    = alu_imm_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_b_sel  = alu_b_sel_q;

`ifdef ALU_ARB_STAT_EN
  logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [15:0] gnt_cnt1_q, gnt_cnt1_d;
  logic [15:0] busy_cnt_q, busy_cnt_d;

  // Next counts: grant counters wrap, busy counter saturates.
  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    busy_cnt_d = busy_cnt_q;
    if (accept_c && !gnt_c) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
    if (accept_c && gnt_c)  gnt_cnt1_d = gnt_cnt1_q + 16'd1;
    if (state_q != ST_IDLE && busy_cnt_q != 16'hFFFF) busy_cnt_d = busy_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_q <= 16'd0;
      gnt_cnt1_q <= 16'd0;
      busy_cnt_q <= 16'd0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
  assign busy_cnt = busy_cnt_q;
`endif

endmodule
